// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default RAM geometry and the complex sample layout.
package fft_pkg;

   localparam int FFT_RAM_ADDR_W = 11;
   localparam int FFT_RAM_DATA_W = 32;

   // One complex FFT sample: real in the upper half, imaginary in the lower half.
   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } fft_sample_t;

endpackage

// File: rtl/fft_sdp_ram_if.sv
// Write/read port bundle of the FFT sample buffer; master is the user, slave is the RAM.
interface fft_sdp_ram_if
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH = FFT_RAM_ADDR_W,
   parameter int DATA_WIDTH = FFT_RAM_DATA_W
);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/fft_sdp_ram_array.sv
// Inferable storage array with synchronous write and synchronous read-first read register.
module fft_sdp_ram_array
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH = FFT_RAM_ADDR_W,
   parameter int DATA_WIDTH = FFT_RAM_DATA_W
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_q
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // No reset here so the array and its read register map onto block RAM.
   // The read samples the pre-write word, giving read-first collisions.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_sdp_ram.sv
// Simple dual-port sample/bin buffer: storage array plus resettable read path and optional output register.
module fft_sdp_ram
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH = FFT_RAM_ADDR_W,
   parameter int DATA_WIDTH = FFT_RAM_DATA_W,
   parameter bit OUTPUT_REG = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   fft_sdp_ram_if.slave  bus
);

   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] rd_stage1;
   logic                  rd_live;
   logic                  wr_en_gated;

   assign wr_en_gated = bus.wr_en & rst_n;

   fft_sdp_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en_gated),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (bus.rd_addr),
      .rd_q    (rd_q)
   );

   // The RAM read register has no reset, so a reset-cleared flag masks it
   // until the first post-reset read has landed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_live <= 1'b0;
      end else begin
         rd_live <= 1'b1;
      end
   end

   assign rd_stage1 = rd_live ? rd_q : '0;

   generate
      if (OUTPUT_REG) begin : g_out_reg
         logic [DATA_WIDTH-1:0] rd_out_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_out_q <= '0;
            end else begin
               rd_out_q <= rd_stage1;
            end
         end

         assign bus.rd_data = rd_out_q;
      end else begin : g_no_out_reg
         assign bus.rd_data = rd_stage1;
      end
   endgenerate

endmodule

// File: tb/tb_fft_sdp_ram.sv
// Scoreboard bench for fft_sdp_ram: both latency builds driven in lockstep against an array model.
module tb_fft_sdp_ram;
   import fft_pkg::*;

   localparam int AW    = FFT_RAM_ADDR_W;
   localparam int DW    = FFT_RAM_DATA_W;
   localparam int DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fft_sdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   fft_sdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   fft_sdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   fft_sdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // One entry per clock edge: what a 1-cycle-latency RAM shows after that edge.
   typedef struct {
      logic [DW-1:0] data;
      bit            check;
      bit            rst_ok;
   } item_t;

   item_t         q0[$];
   item_t         q1[$];
   logic [DW-1:0] ref_mem [DEPTH];
   bit            known   [DEPTH];
   int            errors = 0;
   int            checks = 0;

   task automatic compare(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra);
      bus0.wr_en = we;  bus0.wr_addr = wa;  bus0.wr_data = wd;  bus0.rd_addr = ra;
      bus1.wr_en = we;  bus1.wr_addr = wa;  bus1.wr_data = wd;  bus1.rd_addr = ra;
   endtask

   // Drive one cycle at the falling edge and record the expected read-first result.
   task automatic cycle(input bit rstv, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra);
      item_t it;
      @(negedge clk);
      rst_n = rstv;
      drive(we, wa, wd, ra);
      it.rst_ok = rstv;
      it.data   = rstv ? ref_mem[ra] : '0;
      it.check  = !rstv || known[ra];
      if (rstv && we) begin
         ref_mem[wa] = wd;
         known[wa]   = 1'b1;
      end
      q0.push_back(it);
      q1.push_back(it);
   endtask

   initial begin : mon0
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            it = q0.pop_front();
            if (it.check) compare("rd_lat1", bus0.rd_data, it.data);
         end
      end
   end

   // The output-register build shows the previous edge's result, or 0 if this edge saw reset.
   initial begin : mon1
      item_t         it;
      logic [DW-1:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (q1.size() >= 2) begin
            it  = q1.pop_front();
            exp = q1[0].rst_ok ? it.data : '0;
            if (!q1[0].rst_ok || it.check) compare("rd_lat2", bus1.rd_data, exp);
         end
      end
   end

   initial begin : stim
      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0);
      #1;
      compare("reset_rd0", bus0.rd_data, '0);
      compare("reset_rd1", bus1.rd_data, '0);

      for (int i = 0; i < 20; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, AW'($urandom));

      // Fill 1..2047,0 with decrementing data while reading the word written the cycle before.
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, 1'b1, AW'((i + 1) % DEPTH), 32'hFFFF_FFFF - DW'(i), AW'(i % DEPTH));

      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, 1'b0, '0, '0, AW'((i + 1) % DEPTH));

      cycle(1'b1, 1'b1, AW'(5), 32'h1111_1111, AW'(6));
      cycle(1'b1, 1'b1, AW'(5), 32'h2222_2222, AW'(5));
      cycle(1'b1, 1'b0, '0, '0, AW'(5));

      cycle(1'b1, 1'b1, AW'(7), 32'h0123_4567, AW'(0));
      cycle(1'b1, 1'b0, AW'(7), 32'hDEAD_BEEF, AW'(7));
      cycle(1'b1, 1'b0, '0, '0, AW'(7));

      for (int i = 0; i < 400; i++)
         cycle(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
               AW'($urandom_range(0, 15)));

      for (int k = 0; k < 10; k++)
         cycle(1'b1, 1'b0, '0, '0, AW'(100 + k));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_rst_rd0", bus0.rd_data, '0);
      compare("async_rst_rd1", bus1.rd_data, '0);
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, AW'(3), 32'hBAD0_BAD0, AW'(101));
      for (int k = 0; k < 10; k++)
         cycle(1'b1, 1'b0, '0, '0, AW'(100 + k));
      cycle(1'b1, 1'b0, '0, '0, AW'(3));

      for (int k = 0; k < 3; k++)
         cycle(1'b1, 1'b0, '0, '0, AW'(1));

      for (int t = 0; t < 10 && q0.size() != 0; t++)
         @(posedge clk);
      #2;
      if (q0.size() != 0 || q1.size() > 1) begin
         errors++;
         $display("FAIL drain: %0d/%0d items left in scoreboard", q0.size(), q1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
